oqpsk_burst_ctrl: RTL and testbench

Burst sequencer for the serial-to-parallel I/Q modulator front end. On a start command it drives the modulator's serial bit input and half-rate phase strobe for one complete burst: a fixed preamble, then payload bits pulled from an upstream source over a valid/ready handshake, then zero tail bits. It sits between the framing logic and the differential-precode/I-Q split stage, and owns all burst timing.

---
 rtl/oqpsk_pkg.sv | 27 ++
 rtl/burst_bit_cnt.sv | 32 +++
 rtl/oqpsk_burst_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_oqpsk_burst_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oqpsk_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the OQPSK burst front end: sequencer states, the
// default preamble/tail framing constants and a small sizing helper.
package oqpsk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    PAY  = 2'd2,
    TAIL = 2'd3
  } state_t;

  localparam int          DEF_PREAMBLE_LEN = 32;
  localparam logic [31:0] DEF_PREAMBLE_PAT = 32'hAAAA_AAAA;
  localparam int          DEF_TAIL_LEN     = 8;
  localparam int          DEF_LEN_W        = 12;

  // Largest of three integers, used to size the shared bit counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/burst_bit_cnt.sv
`timescale 1ns/1ps
// Loadable down-counter tracking the bits left in the current burst section.
// The count is "bits remaining after the one currently on the wire", so the
// zero flag marks the last bit of a section and the one flag the bit before.
module burst_bit_cnt #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         one
);

  // Load has priority over decrement; the counter saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign one  = (count == W'(1));

endmodule

// File: rtl/oqpsk_burst_ctrl.sv
`timescale 1ns/1ps
// Burst sequencer for the OQPSK modulator front end: preamble, handshaked
// payload and zero tail, with a half-rate phase strobe. Every output is a
// register computed from the state that the next cycle will be in.
module oqpsk_burst_ctrl
  import oqpsk_pkg::*;
#(
  parameter int          PREAMBLE_LEN = DEF_PREAMBLE_LEN,
  parameter logic [31:0] PREAMBLE_PAT = DEF_PREAMBLE_PAT,
  parameter int          TAIL_LEN     = DEF_TAIL_LEN,
  parameter int          LEN_W        = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] payload_len,
  input  logic             src_bit,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             mod_bit,
  output logic             mod_en,
  output logic             mod_phase,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int CNT_W = max3(LEN_W, $clog2(PREAMBLE_LEN + 1), $clog2(TAIL_LEN + 1));

  state_t             state;
  state_t             state_next;
  logic [LEN_W-1:0]   len_q;
  logic               accept;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;
  logic               cnt_one;
  logic [CNT_W-1:0]   cnt_minus1;

  logic               pat_bit;
  logic               pre_bit;
  logic               src_ready_next;
  logic               mod_bit_next;
  logic               mod_en_next;
  logic               mod_phase_next;
  logic               busy_next;
  logic               done_next;
  logic               underrun_next;

  burst_bit_cnt #(
    .W(CNT_W)
  ) u_bit_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  assign cnt_minus1 = cnt - CNT_W'(1);

  // State register; the next state already describes the bit being emitted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Section sequencing and counter reload on every section entry.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept       = 1'b1;
          state_next   = PRE;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(PREAMBLE_LEN - 1);
        end
      end
      PRE: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          if (len_q != '0) begin
            state_next   = PAY;
            cnt_load_val = CNT_W'(len_q) - CNT_W'(1);
          end else begin
            state_next   = TAIL;
            cnt_load_val = CNT_W'(TAIL_LEN - 1);
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PAY: begin
        if (cnt_zero) begin
          state_next   = TAIL;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(TAIL_LEN - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      TAIL: begin
        if (cnt_zero) begin
          state_next = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs; src_ready looks two cycles ahead
  // so that it leads each payload slot by exactly one cycle.
  always_comb begin
    pat_bit = 1'b0;
    for (int i = 0; i < PREAMBLE_LEN; i++) begin
      if (cnt_minus1 == CNT_W'(i)) pat_bit = PREAMBLE_PAT[i];
    end
    pre_bit = (state == IDLE) ? PREAMBLE_PAT[PREAMBLE_LEN-1] : pat_bit;

    src_ready_next = (accept && (PREAMBLE_LEN == 1) && (payload_len != '0))
                  || ((state == PRE) && cnt_zero && (len_q > LEN_W'(1)))
                  || ((state == PRE) && cnt_one && (len_q != '0))
                  || ((state == PAY) && !cnt_zero && !cnt_one);

    if (src_ready) begin
      mod_bit_next = src_valid & src_bit;
    end else if (state_next == PRE) begin
      mod_bit_next = pre_bit;
    end else begin
      mod_bit_next = 1'b0;
    end

    busy_next   = (state_next != IDLE);
    mod_en_next = (state_next != IDLE);

    if (state_next == IDLE) begin
      mod_phase_next = 1'b0;
    end else if (state == IDLE) begin
      mod_phase_next = 1'b1;
    end else begin
      mod_phase_next = ~mod_phase;
    end

    done_next     = (state == TAIL) && cnt_zero;
    underrun_next = accept ? 1'b0 : (underrun | (src_ready & ~src_valid));
  end

  // Output and latched-length registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q     <= '0;
      src_ready <= 1'b0;
      mod_bit   <= 1'b0;
      mod_en    <= 1'b0;
      mod_phase <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (accept) len_q <= payload_len;
      src_ready <= src_ready_next;
      mod_bit   <= mod_bit_next;
      mod_en    <= mod_en_next;
      mod_phase <= mod_phase_next;
      busy      <= busy_next;
      done      <= done_next;
      underrun  <= underrun_next;
    end
  end

endmodule

// File: tb/tb_oqpsk_burst_ctrl.sv
`timescale 1ns/1ps
// Directed bench for oqpsk_burst_ctrl with default framing (32-bit 0xAAAAAAAA
// preamble, 8 tail bits). Cycle 0 is the cycle in which start is accepted;
// outputs are sampled 1ns after each rising edge.
module tb_oqpsk_burst_ctrl;
  import oqpsk_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] payload_len;
  logic        src_bit;
  logic        src_valid;
  logic        src_ready;
  logic        mod_bit;
  logic        mod_en;
  logic        mod_phase;
  logic        busy;
  logic        done;
  logic        underrun;

  int checks;
  int failures;

  oqpsk_burst_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .payload_len (payload_len),
    .src_bit     (src_bit),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .mod_bit     (mod_bit),
    .mod_en      (mod_en),
    .mod_phase   (mod_phase),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; payload_len = '0; src_bit = 1'b0; src_valid = 1'b0;
    tick();
    tick();
    checks++; if (src_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset.src_ready got %b expected 0", src_ready); end
    checks++; if (mod_bit   !== 1'b0) begin failures++; $display("[TB] FAIL reset.mod_bit got %b expected 0", mod_bit); end
    checks++; if (mod_en    !== 1'b0) begin failures++; $display("[TB] FAIL reset.mod_en got %b expected 0", mod_en); end
    checks++; if (mod_phase !== 1'b0) begin failures++; $display("[TB] FAIL reset.mod_phase got %b expected 0", mod_phase); end
    checks++; if (busy      !== 1'b0) begin failures++; $display("[TB] FAIL reset.busy got %b expected 0", busy); end
    checks++; if (done      !== 1'b0) begin failures++; $display("[TB] FAIL reset.done got %b expected 0", done); end
    checks++; if (underrun  !== 1'b0) begin failures++; $display("[TB] FAIL reset.underrun got %b expected 0", underrun); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [43:0] exp_seq;
    logic [3:0]  pay;
    logic        exp_en, exp_phase, exp_ready, exp_done;
    int          en_cnt;
    exp_seq = {32'hAAAA_AAAA, 4'b1011, 8'h00};
    pay     = 4'b1101;
    en_cnt  = 0;
    payload_len = 12'd4; src_valid = 1'b1; src_bit = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      src_bit   = (c >= 32 && c <= 35) ? pay[c-32] : 1'b0;
      exp_en    = (c <= 44);
      exp_phase = (c <= 44) && (c % 2 == 1);
      exp_ready = (c >= 32 && c <= 35);
      exp_done  = (c == 45);
      if (mod_en === 1'b1) en_cnt++;
      checks++; if (mod_en !== exp_en) begin failures++; $display("[TB] FAIL basic.mod_en cycle %0d got %b expected %b", c, mod_en, exp_en); end
      checks++; if (busy !== exp_en) begin failures++; $display("[TB] FAIL basic.busy cycle %0d got %b expected %b", c, busy, exp_en); end
      if (c <= 44) begin
        checks++; if (mod_bit !== exp_seq[44-c]) begin failures++; $display("[TB] FAIL basic.mod_bit cycle %0d got %b expected %b", c, mod_bit, exp_seq[44-c]); end
      end
      checks++; if (mod_phase !== exp_phase) begin failures++; $display("[TB] FAIL basic.mod_phase cycle %0d got %b expected %b", c, mod_phase, exp_phase); end
      checks++; if (src_ready !== exp_ready) begin failures++; $display("[TB] FAIL basic.src_ready cycle %0d got %b expected %b", c, src_ready, exp_ready); end
      checks++; if (done !== exp_done) begin failures++; $display("[TB] FAIL basic.done cycle %0d got %b expected %b", c, done, exp_done); end
      tick();
    end
    checks++; if (en_cnt != 44) begin failures++; $display("[TB] FAIL basic.en_count got %0d expected 44", en_cnt); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL basic.underrun got %b expected 0", underrun); end
  endtask

  task automatic test_zero_len();
    logic exp_en, exp_bit, exp_phase, exp_done;
    int   en_cnt;
    en_cnt = 0;
    payload_len = 12'd0; src_valid = 1'b1; src_bit = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      exp_en    = (c <= 40);
      exp_bit   = (c <= 32) && (c % 2 == 1);
      exp_phase = (c <= 40) && (c % 2 == 1);
      exp_done  = (c == 41);
      if (mod_en === 1'b1) en_cnt++;
      checks++; if (mod_en !== exp_en) begin failures++; $display("[TB] FAIL zero.mod_en cycle %0d got %b expected %b", c, mod_en, exp_en); end
      if (c <= 40) begin
        checks++; if (mod_bit !== exp_bit) begin failures++; $display("[TB] FAIL zero.mod_bit cycle %0d got %b expected %b", c, mod_bit, exp_bit); end
      end
      checks++; if (mod_phase !== exp_phase) begin failures++; $display("[TB] FAIL zero.mod_phase cycle %0d got %b expected %b", c, mod_phase, exp_phase); end
      checks++; if (src_ready !== 1'b0) begin failures++; $display("[TB] FAIL zero.src_ready cycle %0d got %b expected 0", c, src_ready); end
      checks++; if (done !== exp_done) begin failures++; $display("[TB] FAIL zero.done cycle %0d got %b expected %b", c, done, exp_done); end
      tick();
    end
    checks++; if (en_cnt != 40) begin failures++; $display("[TB] FAIL zero.en_count got %0d expected 40", en_cnt); end
  endtask

  task automatic test_underrun();
    logic exp_en, exp_bit, exp_ready, exp_done, exp_under;
    int   en_cnt;
    en_cnt = 0;
    payload_len = 12'd6; src_valid = 1'b1; src_bit = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      if (c == 1)  payload_len = 12'd1;
      start     = (c == 10);
      src_valid = (c != 34);
      exp_en    = (c <= 46);
      if (c <= 32)      exp_bit = (c % 2 == 1);
      else if (c <= 38) exp_bit = (c != 35);
      else              exp_bit = 1'b0;
      exp_ready = (c >= 32 && c <= 37);
      exp_done  = (c == 47);
      exp_under = (c >= 35);
      if (mod_en === 1'b1) en_cnt++;
      checks++; if (mod_en !== exp_en) begin failures++; $display("[TB] FAIL under.mod_en cycle %0d got %b expected %b", c, mod_en, exp_en); end
      if (c <= 46) begin
        checks++; if (mod_bit !== exp_bit) begin failures++; $display("[TB] FAIL under.mod_bit cycle %0d got %b expected %b", c, mod_bit, exp_bit); end
      end
      checks++; if (src_ready !== exp_ready) begin failures++; $display("[TB] FAIL under.src_ready cycle %0d got %b expected %b", c, src_ready, exp_ready); end
      checks++; if (done !== exp_done) begin failures++; $display("[TB] FAIL under.done cycle %0d got %b expected %b", c, done, exp_done); end
      checks++; if (underrun !== exp_under) begin failures++; $display("[TB] FAIL under.underrun cycle %0d got %b expected %b", c, underrun, exp_under); end
      tick();
    end
    checks++; if (en_cnt != 46) begin failures++; $display("[TB] FAIL under.en_count got %0d expected 46", en_cnt); end
    tick();
    checks++; if (underrun !== 1'b1) begin failures++; $display("[TB] FAIL under.sticky got %b expected 1", underrun); end
    payload_len = 12'd0; src_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL under.clear got %b expected 0", underrun); end
    for (int r = 1; r <= 41; r++) begin
      checks++; if (done !== (r == 41)) begin failures++; $display("[TB] FAIL under.done2 rel %0d got %b expected %b", r, done, (r == 41)); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic exp_en, exp_bit, exp_phase, exp_ready, exp_done;
    int   r;
    payload_len = 12'd2; src_valid = 1'b1; src_bit = 1'b0; start = 1'b1;
    tick();
    for (int c = 1; c <= 86; c++) begin
      r = ((c - 1) % 43) + 1;
      src_bit   = (r == 32);
      exp_en    = (r <= 42);
      if (r <= 32)       exp_bit = (r % 2 == 1);
      else if (r == 33)  exp_bit = 1'b1;
      else               exp_bit = 1'b0;
      exp_phase = (r <= 42) && (r % 2 == 1);
      exp_ready = (r == 32 || r == 33);
      exp_done  = (r == 43);
      checks++; if (mod_en !== exp_en) begin failures++; $display("[TB] FAIL b2b.mod_en cycle %0d got %b expected %b", c, mod_en, exp_en); end
      checks++; if (busy !== exp_en) begin failures++; $display("[TB] FAIL b2b.busy cycle %0d got %b expected %b", c, busy, exp_en); end
      if (r <= 42) begin
        checks++; if (mod_bit !== exp_bit) begin failures++; $display("[TB] FAIL b2b.mod_bit cycle %0d got %b expected %b", c, mod_bit, exp_bit); end
      end
      checks++; if (mod_phase !== exp_phase) begin failures++; $display("[TB] FAIL b2b.mod_phase cycle %0d got %b expected %b", c, mod_phase, exp_phase); end
      checks++; if (src_ready !== exp_ready) begin failures++; $display("[TB] FAIL b2b.src_ready cycle %0d got %b expected %b", c, src_ready, exp_ready); end
      checks++; if (done !== exp_done) begin failures++; $display("[TB] FAIL b2b.done cycle %0d got %b expected %b", c, done, exp_done); end
      if (c == 86) start = 1'b0;
      tick();
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b.idle_after got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    payload_len = 12'd4; src_valid = 1'b1; src_bit = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    checks++; if (mod_en !== 1'b1) begin failures++; $display("[TB] FAIL rmid.mod_en_c20 got %b expected 1", mod_en); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (src_ready !== 1'b0) begin failures++; $display("[TB] FAIL rmid.src_ready got %b expected 0", src_ready); end
    checks++; if (mod_bit   !== 1'b0) begin failures++; $display("[TB] FAIL rmid.mod_bit got %b expected 0", mod_bit); end
    checks++; if (mod_en    !== 1'b0) begin failures++; $display("[TB] FAIL rmid.mod_en got %b expected 0", mod_en); end
    checks++; if (mod_phase !== 1'b0) begin failures++; $display("[TB] FAIL rmid.mod_phase got %b expected 0", mod_phase); end
    checks++; if (busy      !== 1'b0) begin failures++; $display("[TB] FAIL rmid.busy got %b expected 0", busy); end
    checks++; if (done      !== 1'b0) begin failures++; $display("[TB] FAIL rmid.done got %b expected 0", done); end
    checks++; if (underrun  !== 1'b0) begin failures++; $display("[TB] FAIL rmid.underrun got %b expected 0", underrun); end
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL rmid.done_c22 got %b expected 0", done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (mod_en !== 1'b1) begin failures++; $display("[TB] FAIL rmid.restart_en got %b expected 1", mod_en); end
    checks++; if (mod_phase !== 1'b1) begin failures++; $display("[TB] FAIL rmid.restart_phase got %b expected 1", mod_phase); end
    checks++; if (mod_bit !== 1'b1) begin failures++; $display("[TB] FAIL rmid.restart_bit got %b expected 1", mod_bit); end
    for (int r = 2; r <= 45; r++) begin
      tick();
      checks++; if (done !== (r == 45)) begin failures++; $display("[TB] FAIL rmid.done rel %0d got %b expected %b", r, done, (r == 45)); end
      checks++; if (mod_phase !== ((r <= 44) && (r % 2 == 1))) begin failures++; $display("[TB] FAIL rmid.mod_phase rel %0d got %b", r, mod_phase); end
    end
    tick();
  endtask

  // Runs each scenario in turn and prints the summary line.
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
